prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Program loader: takes a byte stream over a valid/ready handshake and writes it
// into program memory starting at base_addr, with a running modulo-256 checksum.
module prog_loader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] byte_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ONE_R  = {{ADDR_W{1'b0}}, 1'b1};
  // A byte_count of zero stands for the full address space.
  localparam logic [ADDR_W:0]   FULL_R = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W:0]   remaining_r;
  logic              xfer_s;
  logic              load_start_s;

  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] b);
    return acc + b;
  endfunction

  // Next-state decode; abort wins over a same-cycle transfer.
  always_comb begin
    state_next_s = state_r;
    xfer_s       = 1'b0;
    load_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = LOAD;
          load_start_s = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          state_next_s = IDLE;
        end else if (in_valid && in_ready) begin
          xfer_s = 1'b1;
          if (remaining_r == ONE_R) begin
            state_next_s = DONE;
          end else begin
            state_next_s = LOAD;
          end
        end else begin
          state_next_s = LOAD;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs; flags are derived from the next state
  // so in_ready/busy are already high in the first cycle after start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= {ADDR_W{1'b0}};
      remaining_r <= {(ADDR_W+1){1'b0}};
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= {ADDR_W{1'b0}};
      mem_wdata   <= {DATA_W{1'b0}};
      checksum    <= {DATA_W{1'b0}};
    end else begin
      state_r  <= state_next_s;
      in_ready <= (state_next_s == LOAD);
      busy     <= (state_next_s == LOAD);
      done     <= (state_next_s == DONE);
      mem_we   <= xfer_s;
      if (load_start_s) begin
        ptr_r       <= base_addr;
        remaining_r <= (byte_count == {ADDR_W{1'b0}}) ? FULL_R : {1'b0, byte_count};
        checksum    <= {DATA_W{1'b0}};
      end else if (xfer_s) begin
        ptr_r       <= ptr_r + ONE_A;
        remaining_r <= remaining_r - ONE_R;
        checksum    <= csum_add(checksum, in_data);
        mem_addr    <= ptr_r;
        mem_wdata   <= in_data;
      end else begin
        ptr_r       <= ptr_r;
        remaining_r <= remaining_r;
        checksum    <= checksum;
      end
    end
  end

endmodule
